hazard_ctrl_mc: RTL

Next-generation pipeline hazard controller for the 5-stage RV32I core. It handles operand forwarding into Execute, load-use stalls, branch flushes, multi-cycle memory waits and a sequenced multi-cycle divider handshake with programmable latency. It also provides saturating stall and flush performance counters. The block sits beside the datapath and drives every stage's enable and flush lines.

---
 rtl/hazard_ctrl_mc.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mc.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_mc
// Hazard controller for a 5-stage RV32I pipeline. Generates Execute operand
// forwarding selects, stage stall/flush lines for load-use, taken branches,
// memory waits and a multi-cycle divider, and keeps saturating counters of
// stall and flush cycles.
//
// Parameters
//   AW          register index width
//   DIV_LATENCY divider compute cycles (>= 1)
//   CNT_W       performance counter width
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   rs1D, rs2D, rs1E, rs2E           source indices in D and E
//   rdE, rdM, rdW                    destination indices in E, M, W
//   RegWriteM, RegWriteW             register write enables in M, W
//   ResultSrcE0, ResultSrcM0         load in E / load in M
//   mem_ready                        load in M has completed
//   PCSrcE                           branch/jump taken in E
//   RtypedivE                        div/rem in E
//   forwardaE, forwardbE             00 regfile, 01 from W, 10 from M
//   stallF/D/E/M                     stage hold
//   flushD/E/M/W                     bubble insert
//   div_start, div_busy, div_done    divider handshake
//   stall_cycles, flush_count        saturating performance counters
//
// Divider FSM
//   state  | meaning
//   IDLE   | no divide in flight; launches when a div reaches E
//   BUSY   | divider computing; counter runs down to zero
//   DONE   | result valid; held here while memory wait is active
// ---------------------------------------------------------------------------
module hazard_ctrl_mc #(
   parameter int AW          = 5,
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    rs1D,
   input  logic [AW-1:0]    rs2D,
   input  logic [AW-1:0]    rs1E,
   input  logic [AW-1:0]    rs2E,
   input  logic [AW-1:0]    rdE,
   input  logic [AW-1:0]    rdM,
   input  logic [AW-1:0]    rdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             ResultSrcM0,
   input  logic             mem_ready,
   input  logic             PCSrcE,
   input  logic             RtypedivE,
   output logic [1:0]       forwardaE,
   output logic [1:0]       forwardbE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             div_start,
   output logic             div_busy,
   output logic             div_done,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int            CW       = $clog2(DIV_LATENCY + 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_div_cnt;
   logic [CW-1:0]    w_div_cnt_nxt;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   logic             w_lwstall;
   logic             w_memstall;
   logic             w_divstall;

   // ------------------------------------------------------------------
   // Forwarding: M has priority over W, x0 is never forwarded
   // ------------------------------------------------------------------
   always_comb begin
      forwardaE = 2'b00;
      if (rs1E != '0) begin
         if (RegWriteM && (rs1E == rdM))
            forwardaE = 2'b10;
         else if (RegWriteW && (rs1E == rdW))
            forwardaE = 2'b01;
      end
   end

   always_comb begin
      forwardbE = 2'b00;
      if (rs2E != '0) begin
         if (RegWriteM && (rs2E == rdM))
            forwardbE = 2'b10;
         else if (RegWriteW && (rs2E == rdW))
            forwardbE = 2'b01;
      end
   end

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   assign w_lwstall  = ResultSrcE0 && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
   assign w_memstall = ResultSrcM0 && !mem_ready;
   assign w_divstall = RtypedivE && (r_state != S_DONE);

   // memstall freezes everything, so no flush may land in a held stage;
   // divstall keeps D and E holding together, so E must not be flushed.
   assign stallF = w_lwstall || w_memstall || w_divstall;
   assign stallD = stallF;
   assign stallE = w_memstall || w_divstall;
   assign stallM = w_memstall;

   assign flushD = PCSrcE && !w_memstall;
   assign flushE = (w_lwstall || PCSrcE) && !w_memstall && !w_divstall;
   assign flushM = w_divstall && !w_memstall;
   assign flushW = w_memstall;

   // ------------------------------------------------------------------
   // Divider FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Divider FSM: next state
   // BUSY countdown is not paused by memstall; only DONE can be stretched.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
      case (r_state)
         S_IDLE: begin
            if (RtypedivE && !w_memstall) begin
               w_state_nxt   = S_BUSY;
               w_div_cnt_nxt = DIV_LOAD;
            end
         end
         S_BUSY: begin
            if (r_div_cnt == '0)
               w_state_nxt = S_DONE;
            else
               w_div_cnt_nxt = r_div_cnt - CW'(1);
         end
         S_DONE: begin
            if (!w_memstall)
               w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_div_cnt_nxt = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Divider FSM: outputs
   // div_start is gated by rst_n so no launch is seen while reset is held.
   // ------------------------------------------------------------------
   always_comb begin
      div_start = 1'b0;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      case (r_state)
         S_IDLE:  div_start = rst_n && RtypedivE && !w_memstall;
         S_BUSY:  div_busy  = 1'b1;
         S_DONE:  div_done  = !w_memstall;
         default: div_start = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (stallF && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (flushD && (r_flush_count != '1))
            r_flush_count <= r_flush_count + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule
